// File: rtl/score_session_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : score_session_ctrl
//  Purpose  : Session controller and round-robin arbiter in front of the score
//             tally/averager. It merges N_REQ score sources onto the tally's
//             single score/score_ready input. It clears the tally at session
//             start and counts accepted scores. After MAX_SCORES scores it ends
//             the session and raises done.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk               in   1         system clock, rising edge
//    reset             in   1         asynchronous, active-low reset
//    start             in   1         begin new session (level, IDLE/DONE only)
//    abort             in   1         cancel session immediately
//    req               in   N_REQ     per-source score valid, held until granted
//    score_in          in   4*N_REQ   per-source 4-bit score, source i at [4i+3:4i]
//    grant             out  N_REQ     one-hot, 1-cycle acknowledge to the winner
//    tally_clr         out  1         1-cycle clear pulse to the tally
//    tally_score       out  4         score forwarded to the tally
//    tally_score_ready out  1         1-cycle strobe to the tally
//    scores_taken      out  CNT_W     scores accepted this session
//    busy              out  1         high in CLEAR/RUN/DRAIN
//    done              out  1         high in DONE
//    timed_out         out  1         session ended by the idle timeout
//  Configuration macro
//    SCORE_TIMEOUT_EN  enables the RUN idle timeout. When it is not defined,
//                      timed_out is tied low.
// ============================================================================
module score_session_ctrl #(
  parameter int N_REQ          = 4,
  parameter int MAX_SCORES     = 1024,
  parameter int TIMEOUT_CYCLES = 48000,
  localparam int CNT_W         = $clog2(MAX_SCORES + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [N_REQ-1:0]   req,
  input  logic [4*N_REQ-1:0] score_in,
  output logic [N_REQ-1:0]   grant,
  output logic               tally_clr,
  output logic [3:0]         tally_score,
  output logic               tally_score_ready,
  output logic [CNT_W-1:0]   scores_taken,
  output logic               busy,
  output logic               done,
  output logic               timed_out
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [PTR_W-1:0]   rr_ptr;
  logic               win_found;
  logic [PTR_W-1:0]   win_idx;
  logic [3:0]         win_score;
  logic               take;
  logic               timeout_hit;

  // --------------------------------------------------------------------------
  // Round-robin search. Offset k counts positions after the pointer, so the
  // first hit in k order is the lowest index at or after rr_ptr, wrapping
  // modulo N_REQ. The inner loop keeps every req/score select at a constant
  // index.
  // --------------------------------------------------------------------------
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    win_score = '0;
    for (int k = 0; k < N_REQ; k++) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (!win_found && req[i] && (i == ((int'(rr_ptr) + k) % N_REQ))) begin
          win_found = 1'b1;
          win_idx   = PTR_W'(i);
          win_score = score_in[4*i +: 4];
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Optional idle timeout
  // --------------------------------------------------------------------------
`ifdef SCORE_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [IDLE_W-1:0] idle_cnt;
  logic              timed_out_r;

  // The counter holds the number of grant-free RUN cycles already completed.
  // The timeout fires on the cycle that would make that count TIMEOUT_CYCLES.
  assign timeout_hit = (state == RUN) && !abort && !win_found &&
                       (idle_cnt == IDLE_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idle_cnt    <= '0;
      timed_out_r <= 1'b0;
    end else begin
      if (state == CLEAR) begin
        idle_cnt    <= '0;
        timed_out_r <= 1'b0;
      end else if (state == RUN) begin
        if (take) begin
          idle_cnt <= '0;
        end else if (!timeout_hit) begin
          idle_cnt <= idle_cnt + IDLE_W'(1);
        end
        if (timeout_hit) begin
          timed_out_r <= 1'b1;
        end
      end
    end
  end

  assign timed_out = timed_out_r;
`else
  assign timeout_hit = 1'b0;
  assign timed_out   = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state and grant decision
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    case (state)
      IDLE: begin
        if (start && !abort) begin
          state_nxt = CLEAR;
        end
      end
      CLEAR: begin
        state_nxt = abort ? IDLE : RUN;
      end
      RUN: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (win_found && (scores_taken != CNT_W'(MAX_SCORES))) begin
          take = 1'b1;
          // The final grant and the move to DRAIN happen on the same edge.
          if (scores_taken == CNT_W'(MAX_SCORES - 1)) begin
            state_nxt = DRAIN;
          end
        end else if (timeout_hit) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        state_nxt = abort ? IDLE : DONE;
      end
      DONE: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (start) begin
          state_nxt = CLEAR;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Registered datapath: grant, strobe, forwarded score, counter, rr pointer
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grant             <= '0;
      tally_score_ready <= 1'b0;
      tally_score       <= '0;
      scores_taken      <= '0;
      rr_ptr            <= '0;
    end else begin
      grant             <= '0;
      tally_score_ready <= 1'b0;
      if (state == CLEAR) begin
        scores_taken <= '0;
      end
      if (take) begin
        grant             <= N_REQ'(1) << win_idx;
        tally_score       <= win_score;
        tally_score_ready <= 1'b1;
        scores_taken      <= scores_taken + CNT_W'(1);
        rr_ptr            <= (win_idx == PTR_W'(N_REQ - 1)) ? '0 : (win_idx + PTR_W'(1));
      end
    end
  end

  // These outputs decode the state register directly, so they stay registered.
  assign tally_clr = (state == CLEAR);
  assign busy      = (state == CLEAR) || (state == RUN) || (state == DRAIN);
  assign done      = (state == DONE);

endmodule
`default_nettype wire

// File: tb/tb_score_session_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_score_session_ctrl
//  Purpose  : Self-checking bench for score_session_ctrl. A session-level
//             reference model predicts every output on every cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_score_session_ctrl;

  localparam int N    = 4;
  localparam int MAXS = 5;
  localparam int TMO  = 8;
  localparam int CW   = $clog2(MAXS + 1);
`ifdef SCORE_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           start = 1'b0;
  logic           abort = 1'b0;
  logic [N-1:0]   req = '0;
  logic [4*N-1:0] score_in = '0;
  logic [N-1:0]   grant;
  logic           tally_clr;
  logic [3:0]     tally_score;
  logic           tally_score_ready;
  logic [CW-1:0]  scores_taken;
  logic           busy;
  logic           done;
  logic           timed_out;

  always #5 clk = ~clk;

  score_session_ctrl #(
    .N_REQ(N), .MAX_SCORES(MAXS), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .req(req), .score_in(score_in), .grant(grant), .tally_clr(tally_clr),
    .tally_score(tally_score), .tally_score_ready(tally_score_ready),
    .scores_taken(scores_taken), .busy(busy), .done(done), .timed_out(timed_out)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: session phase (idle/clearing/running/draining/finished),
  // plus the fairness pointer, counts, and the last forwarded score.
  typedef enum int {P_IDLE, P_CLEAR, P_RUN, P_DRAIN, P_DONE} phase_t;
  phase_t m_phase;
  int     m_ptr, m_cnt, m_idle, m_score, m_grant;
  bit     m_to, m_ready;

  // Synthetic requesters: each keeps its request until it sees its grant.
  bit       pend [N];
  bit [3:0] psc  [N];

  task automatic model_reset();
    m_phase = P_IDLE; m_ptr = 0; m_cnt = 0; m_idle = 0;
    m_score = 0; m_grant = 0; m_to = 0; m_ready = 0;
  endtask

  task automatic model_step();
    int w;
    m_grant = 0;
    m_ready = 0;
    w = -1;
    case (m_phase)
      P_IDLE:  if (start && !abort) m_phase = P_CLEAR;
      P_CLEAR: begin
        m_cnt = 0; m_to = 0; m_idle = 0;
        m_phase = abort ? P_IDLE : P_RUN;
      end
      P_RUN: begin
        if (abort) m_phase = P_IDLE;
        else begin
          for (int k = 0; k < N; k++)
            if (w < 0 && req[(m_ptr + k) % N]) w = (m_ptr + k) % N;
          if (w >= 0) begin
            m_grant = 1 << w;
            m_ready = 1;
            m_score = (score_in >> (4 * w)) & 15;
            m_cnt++;
            m_ptr = (w + 1) % N;
            m_idle = 0;
            if (m_cnt == MAXS) m_phase = P_DRAIN;
          end else begin
            m_idle++;
            if (TO_EN && m_idle == TMO) begin
              m_phase = P_DRAIN;
              m_to = 1;
            end
          end
        end
      end
      P_DRAIN: m_phase = abort ? P_IDLE : P_DONE;
      P_DONE:  if (abort) m_phase = P_IDLE; else if (start) m_phase = P_CLEAR;
      default: m_phase = P_IDLE;
    endcase
  endtask

  task automatic check_all();
    check("busy",  busy, (m_phase == P_CLEAR || m_phase == P_RUN || m_phase == P_DRAIN));
    check("done",  done, (m_phase == P_DONE));
    check("clr",   tally_clr, (m_phase == P_CLEAR));
    check("grant", grant, m_grant);
    check("ready", tally_score_ready, m_ready);
    check("score", tally_score, m_score);
    check("taken", scores_taken, m_cnt);
    check("tmo",   timed_out, m_to);
  endtask

  // One clock: drive at negedge, model at posedge, compare 1 ns later.
  task automatic cycle(input bit s, input bit a, input bit use_src,
                       input logic [N-1:0] r, input logic [4*N-1:0] sc);
    @(negedge clk);
    start = s;
    abort = a;
    if (use_src) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1'b1;
          psc[i]  = 4'($urandom_range(0, 15));
        end
        req[i] = pend[i];
        score_in[4*i +: 4] = psc[i];
      end
    end else begin
      req = r;
      score_in = sc;
    end
    @(posedge clk);
    model_step();
    #1;
    check_all();
    if (use_src)
      for (int i = 0; i < N; i++)
        if (m_grant[i]) pend[i] = 1'b0;
  endtask

  task automatic idle_cycles(input int n, input logic [N-1:0] r, input logic [4*N-1:0] sc);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, r, sc);
  endtask

  // Asynchronous reset applied between clock edges.
  task automatic async_reset();
    #2;
    reset = 1'b0;
    #1;
    check("arst_busy",  busy, 0);
    check("arst_grant", grant, 0);
    check("arst_ready", tally_score_ready, 0);
    check("arst_taken", scores_taken, 0);
    check("arst_score", tally_score, 0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  initial begin
    model_reset();
    for (int i = 0; i < N; i++) begin pend[i] = 1'b0; psc[i] = 4'd0; end

    // Power-on reset
    repeat (2) @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    reset = 1'b1;

    // All four sources requesting: rotating grants 1,2,3,4,1
    cycle(1'b1, 1'b0, 1'b0, 4'hF, 16'h4321);
    idle_cycles(8, 4'hF, 16'h4321);
    check("t2_done", done, 1);
    check("t2_taken", scores_taken, MAXS);

    // Abort from DONE, then start+abort together in IDLE
    cycle(1'b0, 1'b1, 1'b0, 4'h0, 16'h0);
    cycle(1'b1, 1'b1, 1'b0, 4'h0, 16'h0);
    check("t4_idle_busy", busy, 0);

    // Single source on index 2 with score 9 until the session ends
    cycle(1'b1, 1'b0, 1'b0, 4'b0100, 16'h0900);
    idle_cycles(10, 4'b0100, 16'h0900);
    check("t3_taken", scores_taken, MAXS);
    check("t3_done", done, 1);
    check("t3_score", tally_score, 9);

    // Abort on the second RUN cycle with requests pending
    cycle(1'b1, 1'b0, 1'b0, 4'b1010, 16'h5060);
    idle_cycles(2, 4'b1010, 16'h5060);
    cycle(1'b0, 1'b1, 1'b0, 4'b1010, 16'h5060);
    check("t4_abort_busy", busy, 0);
    check("t4_abort_grant", grant, 0);
    idle_cycles(2, 4'b1010, 16'h5060);

    // No requests after start: timeout build drains, default build stays in RUN
    cycle(1'b1, 1'b0, 1'b0, 4'h0, 16'h0);
    idle_cycles(TMO + 4, 4'h0, 16'h0);
    check("t5_done", done, TO_EN);
    check("t5_busy", busy, !TO_EN);

    // Start pulsed while running is ignored
    cycle(1'b0, 1'b1, 1'b0, 4'h0, 16'h0);
    cycle(1'b1, 1'b0, 1'b0, 4'h0, 16'h0);
    idle_cycles(2, 4'b0001, 16'h0007);
    cycle(1'b1, 1'b0, 1'b0, 4'h0, 16'h0);
    check("t6_clr", tally_clr, 0);
    idle_cycles(1, 4'h0, 16'h0);

    // Reset asserted mid-RUN with grants active, then a fresh start
    cycle(1'b0, 1'b1, 1'b0, 4'h0, 16'h0);
    cycle(1'b1, 1'b0, 1'b0, 4'hF, 16'hABCD);
    idle_cycles(3, 4'hF, 16'hABCD);
    async_reset();
    cycle(1'b1, 1'b0, 1'b0, 4'h0, 16'h0);
    check("t1_clr", tally_clr, 1);
    idle_cycles(2, 4'h0, 16'h0);

    // Randomized sessions with realistic requesters
    for (int c = 0; c < 3000; c++) begin
      cycle($urandom_range(0, 5) == 0, $urandom_range(0, 49) == 0, 1'b1, '0, '0);
      if (c % 700 == 350) async_reset();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
